// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide execution stage.
//   Shift-add multiply / restoring divide on operand magnitudes, one bit per
//   clock (32 CALC cycles), followed by one FIX cycle that applies the sign.
//   Divide-by-zero and signed overflow bypass the datapath and answer at once.
// Ports:
//   clk, rst        rising-edge clock, async active-high reset
//   start           request, accepted in IDLE or DONE
//   funct3          RV32M op select (MUL..REMU)
//   op_a, op_b      rs1 / rs2 operands
//   rd_in           destination tag, returned on rd_out with the result
//   busy            stall request while CALC/FIX
//   done            one-cycle write-back strobe; result/rd_out valid
//   result, rd_out  held until the next done
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]   LAST = CW'(XLEN-1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      func_q, func_d;
  logic [4:0]      rd_q, rd_d, rd_out_q, rd_out_d;
  logic            neg_q, neg_d;          // negate product / quotient
  logic            neg_rem_q, neg_rem_d;  // remainder takes dividend sign
  logic [XLEN-1:0] hi_q, hi_d;            // product high / partial remainder
  logic [XLEN-1:0] lo_q, lo_d;            // multiplier->product low / dividend->quotient
  logic [XLEN-1:0] b_q, b_d;              // multiplicand or divisor magnitude
  logic [XLEN-1:0] result_q, result_d;

  // Request decode
  logic            is_div, a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_val;

  always_comb begin
    is_div   = funct3[2];
    a_sgn    = is_div ? ~funct3[0] : (funct3 != 3'd3);
    b_sgn    = is_div ? ~funct3[0] : ~funct3[1];
    a_neg    = a_sgn & op_a[XLEN-1];
    b_neg    = b_sgn & op_b[XLEN-1];
    a_mag    = a_neg ? -op_a : op_a;
    b_mag    = b_neg ? -op_b : op_b;
    div_zero = is_div && (op_b == '0);
    div_ovf  = is_div && !funct3[0] && (op_a == SMIN) && (op_b == '1);
    special  = div_zero | div_ovf;
    // funct3[1] selects remainder for the divide group
    if (div_zero) special_val = funct3[1] ? op_a : '1;
    else          special_val = funct3[1] ? '0   : SMIN;
  end

  // Datapath step and sign fix-up
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_val;

  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_sh   = {hi_q, lo_q[XLEN-1]};
    div_diff = div_sh - {1'b0, b_q};
    prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    quo_fix  = neg_q ? -lo_q : lo_q;
    rem_fix  = neg_rem_q ? -hi_q : hi_q;
    if (func_q[2])                fix_val = func_q[1] ? rem_fix : quo_fix;
    else if (func_q[1:0] == 2'd0) fix_val = prod_fix[XLEN-1:0];
    else                          fix_val = prod_fix[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    func_d    = func_q;
    rd_d      = rd_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    b_d       = b_q;
    result_d  = result_q;
    rd_out_d  = rd_out_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          func_d = funct3;
          rd_d   = rd_in;
          if (special) begin
            state_d  = DONE;
            result_d = special_val;
            rd_out_d = rd_in;
          end else begin
            state_d   = CALC;
            cnt_d     = '0;
            hi_d      = '0;
            lo_d      = is_div ? a_mag : b_mag;
            b_d       = is_div ? b_mag : a_mag;
            neg_d     = a_neg ^ b_neg;
            neg_rem_d = a_neg;
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = FIX;
        if (func_q[2]) begin
          // restoring step: keep the subtraction only if it did not borrow
          if (!div_diff[XLEN]) begin
            hi_d = div_diff[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_d = div_sh[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b0};
          end
        end else begin
          hi_d = mul_sum[XLEN:1];
          lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
      end
      FIX: begin
        state_d  = DONE;
        result_d = fix_val;
        rd_out_d = rd_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      func_q    <= '0;
      rd_q      <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      b_q       <= '0;
      result_q  <= '0;
      rd_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      func_q    <= func_d;
      rd_q      <= rd_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      b_q       <= b_d;
      result_q  <= result_d;
      rd_out_q  <= rd_out_d;
    end
  end

  assign busy   = (state_q == CALC) || (state_q == FIX);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution stage.
- Consumes the register file's rs1_val/rs2_val operands and produces the write-back value:
  - result drives wd.
  - done drives reg_write.
  - rd_out drives rd.
- busy is the core's stall request while an M-extension operation is in flight.
- Shift-add multiply and restoring divide on magnitudes, one bit per clock, with a final sign-fixup cycle.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported. Internal product is 2*XLEN.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request; sampled on a rising edge when the unit is not busy.
- funct3  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- op_a  input  XLEN  rs1 operand (multiplicand/dividend).
- op_b  input  XLEN  rs2 operand (multiplier/divisor).
- rd_in  input  5  destination register tag.
- busy  output  1  high while an operation is executing; new start is ignored.
- done  output  1  one-cycle pulse; result/rd_out valid.
- result  output  XLEN  operation result; held until next done.
- rd_out  output  5  tag captured at start; held until next done.

Behaviour:
- Reset (async, immediate, any state): state=IDLE; busy=0, done=0, result=0, rd_out=0; internal registers cleared.
  - An operation in progress is abandoned with no done.
- States: IDLE, CALC, FIX, DONE. busy = (state==CALC or FIX). done = (state==DONE).
- Accept condition: start=1 at a rising edge while state is IDLE or DONE.
  - On accept, latch funct3, op_a, op_b and rd_in.
  - Operand or tag changes after acceptance have no effect.
  - start while busy is ignored; it is not queued.
- Normal path: accept edge -> CALC; 32 CALC edges (counter 0..31) -> FIX; 1 FIX edge -> DONE; 1 edge -> IDLE, unless a new start is accepted, which goes to CALC or DONE.
  - done is high in the cycle following edge 34, counting the accept edge as edge 1.
  - busy is high for exactly 33 cycles.
- Special path: divide ops with op_b==0, or DIV/REM with op_a=0x80000000 and op_b=0xFFFFFFFF.
  - Accept edge goes directly to DONE; done is high the cycle after the accept edge.
  - busy stays 0.
- Back-to-back: start in a DONE cycle is accepted on that edge. done then drops unless the new op is special-path.
- Multiply:
  - Magnitudes are taken per signedness: MUL/MULH both signed; MULHSU op_a signed, op_b unsigned; MULHU both unsigned.
  - 64-bit unsigned product; FIX negates it (two's complement, 64 bits) if the operand signs differ.
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
- Divide:
  - Magnitudes are taken for DIV/REM; raw operands for DIVU/REMU.
  - Restoring division produces a 32-bit quotient and remainder.
  - FIX, for DIV, negates the quotient if the signs differ.
  - FIX, for REM, gives the remainder the sign of the dividend.
- Divide by zero: quotient=0xFFFFFFFF (DIV and DIVU); remainder=op_a (REM and REMU).
- Signed overflow: DIV=0x80000000, REM=0.
- result and rd_out update only on entry to DONE. They hold between operations and through busy.
- No exceptions or traps are generated.

Test Plan:
- MUL op_a=7, op_b=0xFFFFFFFD -> result=0xFFFFFFEB; done exactly 34 edges after accept; busy high 33 cycles; rd_out=rd_in.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MUL 0x12345678 x 0 -> 0.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF.
- Special path, done one cycle after accept, busy never high:
  - DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0.
- Protocol:
  - start pulsed at CALC cycle 5 with different operands -> ignored, original result delivered.
  - op_a changed mid-op -> no effect.
  - start asserted in DONE cycle -> second op completes 34 edges later with a correct result.
- Reset: rst asserted asynchronously mid-edge-window at CALC cycle 10 -> busy, done, result and rd_out go to 0 without waiting for clk, and no done follows. After release, MULHU 3x5 completes with result 0.
